// File: rtl/ibex_hpm_counters.sv
// ibex_hpm_counters: M-mode counter bank holding mcycle, minstret and the
// mhpmcounterK registers, with their mhpmevent selectors and mcountinhibit.
// Ports:
//   clk_i, rst_i    clock and synchronous active-high reset
//   csr_addr_i      CSR address
//   csr_we_i        write strobe
//   csr_wdata_i     resolved write data
//   csr_rdata_o     read data, combinational from registered state
//   csr_addr_hit_o  address belongs to this bank
//   instr_ret_i     one instruction retired this cycle
//   event_i         per-cycle event strobes
//   cnt_ovf_o       one-cycle overflow pulse per counter index
module ibex_hpm_counters #(
    parameter int MHPMCounterNum   = 8,
    parameter int MHPMCounterWidth = 40,
    parameter int NumEvents        = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [11:0]          csr_addr_i,
    input  logic                 csr_we_i,
    input  logic [31:0]          csr_wdata_i,
    output logic [31:0]          csr_rdata_o,
    output logic                 csr_addr_hit_o,
    input  logic                 instr_ret_i,
    input  logic [NumEvents-1:0] event_i,
    output logic [31:0]          cnt_ovf_o
);

    function automatic logic [31:0] impl_mask();
        logic [31:0] m;
        m = '0;
        for (int k = 0; k < 32; k++) begin
            m[k] = (k == 0) || (k == 2) ||
                   (k >= 3 && k < 3 + MHPMCounterNum);
        end
        return m;
    endfunction

    localparam logic [31:0] InhMask = impl_mask();

    logic [4:0]  idx;
    logic        sel_inh;
    logic        sel_evt;
    logic        sel_lo;
    logic        sel_hi;
    logic [31:0] inhibit;
    logic [63:0] cnt [32];
    logic [31:0] evt [32];

    // Counter index lives in the low five address bits of every group.
    // Index 1 is the time CSR, which is not owned here.
    assign idx     = csr_addr_i[4:0];
    assign sel_inh = (csr_addr_i == 12'h320);
    assign sel_evt = (csr_addr_i[11:5] == 7'h19) && (idx >= 5'd3);
    assign sel_lo  = (csr_addr_i[11:5] == 7'h58) && (idx != 5'd1);
    assign sel_hi  = (csr_addr_i[11:5] == 7'h5C) && (idx != 5'd1);

    assign csr_addr_hit_o = sel_inh | sel_evt | sel_lo | sel_hi;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inhibit <= '0;
        end else if (csr_we_i && sel_inh) begin
            inhibit <= csr_wdata_i & InhMask;
        end
    end

    for (genvar k = 0; k < 32; k++) begin : g_cnt
        localparam bit Impl = InhMask[k];
        localparam int CW   = (k < 3) ? 64 : MHPMCounterWidth;

        if (Impl) begin : g_on
            logic [CW-1:0] val;
            logic [63:0]   cur;
            logic          inc;
            logic          ovf;
            logic          wr_lo;
            logic          wr_hi;

            assign wr_lo = csr_we_i && sel_lo && (idx == 5'(k));
            assign wr_hi = csr_we_i && sel_hi && (idx == 5'(k));
            assign cur   = 64'(val);

            if (k == 0) begin : g_cycle
                assign inc    = ~inhibit[0];
                assign evt[k] = '0;
            end else if (k == 2) begin : g_instret
                assign inc    = instr_ret_i & ~inhibit[2];
                assign evt[k] = '0;
            end else begin : g_hpm
                logic [NumEvents-1:0] sel;

                always_ff @(posedge clk_i) begin
                    if (rst_i) begin
                        sel <= '0;
                    end else if (csr_we_i && sel_evt &&
                                 (idx == 5'(k))) begin
                        sel <= csr_wdata_i[NumEvents-1:0];
                    end
                end

                // Several selected events in one cycle still count once.
                assign inc    = (|(event_i & sel)) & ~inhibit[k];
                assign evt[k] = 32'(sel);
            end

            // A write takes priority and swallows that cycle's increment.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    val <= '0;
                    ovf <= 1'b0;
                end else begin
                    ovf <= 1'b0;
                    if (wr_lo || wr_hi) begin
                        val <= CW'(wr_lo ?
                                   {cur[63:32], csr_wdata_i} :
                                   {csr_wdata_i, cur[31:0]});
                    end else if (inc) begin
                        val <= val + CW'(1);
                        ovf <= &val;
                    end
                end
            end

            assign cnt[k]       = cur;
            assign cnt_ovf_o[k] = ovf;
        end else begin : g_off
            assign cnt[k]       = '0;
            assign evt[k]       = '0;
            assign cnt_ovf_o[k] = 1'b0;
        end
    end

    always_comb begin
        csr_rdata_o = '0;
        unique case (1'b1)
            sel_inh: csr_rdata_o = inhibit;
            sel_evt: csr_rdata_o = evt[idx];
            sel_lo:  csr_rdata_o = cnt[idx][31:0];
            sel_hi:  csr_rdata_o = cnt[idx][63:32];
            default: csr_rdata_o = '0;
        endcase
    end

endmodule
